// File: rtl/mm_csa_if.sv
// Handshake and operand bus between the point-arithmetic scheduler and the
// Montgomery multiplier sequencer.
interface mm_csa_if #(
    parameter int WIDTH = 256
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] m;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, a, b, m,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, m,
        output busy, done, result
    );
endinterface

// File: rtl/mm_csa_ctrl.sv
// Radix-2 Montgomery multiplier: one bit of a per cycle through two carry-save
// levels, then one carry-propagate add and one conditional subtract.
module mm_csa_ctrl #(
    parameter int WIDTH = 256
) (
    input logic    clk,
    input logic    rst,
    mm_csa_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int SW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ITER, ADD, RED} state_t;
    typedef logic [SW-1:0] acc_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    acc_t             s_r;
    acc_t             c_r;
    acc_t             r_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;

    acc_t addend_b;
    acc_t addend_m;
    acc_t s1;
    acc_t c1;
    acc_t s2;
    acc_t c2;
    logic q;

    function automatic acc_t csa_sum(input acc_t x, input acc_t y, input acc_t z);
        return x ^ y ^ z;
    endfunction

    // Majority bit weighs twice the sum bit, so it moves up one position.
    function automatic acc_t csa_carry(input acc_t x, input acc_t y, input acc_t z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // R < 2*M on entry, so a single subtract fully reduces it.
    function automatic logic [WIDTH-1:0] cond_sub(input acc_t r, input logic [WIDTH-1:0] mod);
        acc_t mod_ext;
        acc_t diff;
        mod_ext = {2'b00, mod};
        diff    = r - mod_ext;
        return (r >= mod_ext) ? diff[WIDTH-1:0] : r[WIDTH-1:0];
    endfunction

    always_comb begin
        addend_b = a_r[cnt] ? {2'b00, b_r} : '0;
        s1       = csa_sum(s_r, c_r, addend_b);
        c1       = csa_carry(s_r, c_r, addend_b);
        q        = s1[0];
        addend_m = q ? {2'b00, m_r} : '0;
        s2       = csa_sum(s1, c1, addend_m);
        c2       = csa_carry(s1, c1, addend_m);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            s_r      <= '0;
            c_r      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        m_r    <= bus.m;
                        s_r    <= '0;
                        c_r    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    // q makes s2+c2 even, so the halving is exact.
                    s_r <= s2 >> 1;
                    c_r <= c2 >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= ADD;
                end
                ADD: begin
                    r_r   <= s_r + c_r;
                    state <= RED;
                end
                RED: begin
                    result_r <= cond_sub(r_r, m_r);
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
endmodule
